// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with optional zero register, write bypass
// and a pending-write scoreboard for RAW/WAW hazard detection at decode.
// Ports: Clk, Rst (sync, active-high); read ports R1_*/R2_* (Addr, en -> Data, Busy);
// write port W_Addr/W_en/W_Data; reserve port Rsv_Addr/Rsv_en;
// Stall = R1_Busy | R2_Busy; Rsv_Waw (registered pulse); Pending_Cnt (registered).
module regfile_sb #(
  parameter int D_WIDTH  = 32,
  parameter int RA_WIDTH = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [RA_WIDTH-1:0] R1_Addr,
  input  logic                R1_en,
  output logic [D_WIDTH-1:0]  R1_Data,
  output logic                R1_Busy,
  input  logic [RA_WIDTH-1:0] R2_Addr,
  input  logic                R2_en,
  output logic [D_WIDTH-1:0]  R2_Data,
  output logic                R2_Busy,
  input  logic [RA_WIDTH-1:0] W_Addr,
  input  logic                W_en,
  input  logic [D_WIDTH-1:0]  W_Data,
  input  logic [RA_WIDTH-1:0] Rsv_Addr,
  input  logic                Rsv_en,
  output logic                Stall,
  output logic                Rsv_Waw,
  output logic [RA_WIDTH:0]   Pending_Cnt
);

  localparam int DEPTH = 2**RA_WIDTH;
  localparam logic [RA_WIDTH:0] ONE = (RA_WIDTH+1)'(1);

  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]   pend;

  logic w_eff;
  logic r_eff;
  logic inc;
  logic dec;

  always_comb begin
    w_eff = W_en;
    if (ZERO_REG != 0 && W_Addr == '0) w_eff = 1'b0;
    r_eff = Rsv_en;
    if (ZERO_REG != 0 && Rsv_Addr == '0) r_eff = 1'b0;
    // A same-address reserve re-arms the bit the write clears.
    inc = r_eff && !pend[Rsv_Addr];
    dec = w_eff && pend[W_Addr]
       && !(r_eff && (Rsv_Addr == W_Addr));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend        <= '0;
      Pending_Cnt <= '0;
      Rsv_Waw     <= 1'b0;
    end else begin
      if (w_eff) begin
        mem[W_Addr]  <= W_Data;
        pend[W_Addr] <= 1'b0;
      end
      // Later assignment wins: the reservation is the newer instruction.
      if (r_eff) pend[Rsv_Addr] <= 1'b1;
      Rsv_Waw <= r_eff && pend[Rsv_Addr];
      case ({inc, dec})
        2'b10:   Pending_Cnt <= Pending_Cnt + ONE;
        2'b01:   Pending_Cnt <= Pending_Cnt - ONE;
        default: Pending_Cnt <= Pending_Cnt;
      endcase
    end
  end

  // Returns {busy, data} for one read port.
  function automatic logic [D_WIDTH:0] rd(
    input logic                en,
    input logic [RA_WIDTH-1:0] a
  );
    if (!en)
      rd = '0;
    else if (ZERO_REG != 0 && a == '0)
      rd = '0;
    else if (BYPASS != 0 && w_eff && W_Addr == a)
      rd = {1'b0, W_Data};
    else
      rd = {pend[a], mem[a]};
  endfunction

  always_comb begin
    {R1_Busy, R1_Data} = rd(R1_en, R1_Addr);
    {R2_Busy, R2_Data} = rd(R2_en, R2_Addr);
    Stall = R1_Busy | R2_Busy;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the MIPS general-purpose register file. It provides two combinational read ports and one synchronous write port. It adds an optional hardwired zero register, optional write-to-read bypass, and a per-register pending-write scoreboard. The scoreboard lets the decode stage detect RAW hazards against in-flight destinations. The block sits between decode (read/reserve) and writeback (write/clear) in the pipelined GPP.

Parameters:
D_WIDTH, 32, data width of each register.
RA_WIDTH, 5, address width; depth = 2**RA_WIDTH.
ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never pending.
BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports.

Ports:
Clk  in  1  clock; all state updates on rising edge.
Rst  in  1  synchronous, active-high reset.
R1_Addr  in  RA_WIDTH  read port 1 address.
R1_en  in  1  read port 1 enable.
R1_Data  out  D_WIDTH  read port 1 data (combinational).
R1_Busy  out  1  read port 1 source has a pending write.
R2_Addr, R2_en, R2_Data, R2_Busy  same as port 1, for read port 2.
W_Addr  in  RA_WIDTH  write address.
W_en  in  1  write enable (writeback).
W_Data  in  D_WIDTH  write data.
Rsv_Addr  in  RA_WIDTH  destination to mark pending.
Rsv_en  in  1  reserve enable (issue).
Stall  out  1  R1_Busy | R2_Busy.
Rsv_Waw  out  1  registered one-cycle pulse: last cycle reserved an already-pending register.
Pending_Cnt  out  RA_WIDTH+1  number of registers currently pending (registered).

Behaviour:
- Reset (Rst=1 at a Clk edge):
  - All registers clear to 0.
  - All pending bits clear to 0.
  - Pending_Cnt clears to 0 and Rsv_Waw clears to 0.
  - Rst has priority over W_en and Rsv_en in that cycle.
  - Reset mid-operation discards all outstanding reservations.
- Write: at the edge with W_en=1, RegFile[W_Addr] <= W_Data and pending[W_Addr] <= 0.
  - Exception: ZERO_REG=1 and W_Addr=0, in which case nothing changes.
- Reserve: at the edge with Rsv_en=1, pending[Rsv_Addr] <= 1.
  - Ignored when ZERO_REG=1 and Rsv_Addr=0.
- Simultaneous write and reserve, same address: the data is written and the pending bit ends at 1, because the reservation belongs to a newer instruction.
- Simultaneous write and reserve, different addresses: both take effect independently.
- Read port n, all combinational, evaluated in priority order:
  1. Rn_en=0: Rn_Data=0, Rn_Busy=0. Outputs are zero, not high-Z.
  2. ZERO_REG=1 and Rn_Addr=0: Data=0, Busy=0.
  3. BYPASS=1, W_en=1, W_Addr=Rn_Addr and the write is not suppressed: Data=W_Data, Busy=0.
  4. Otherwise: Data=RegFile[Rn_Addr], Busy=pending[Rn_Addr].
- With BYPASS=0, a read of the address being written returns the old value plus its old pending bit. The new value is visible the next cycle.
- Stall = R1_Busy | R2_Busy, combinational.
- Same-cycle Rsv_en does not affect Busy. A reservation becomes visible the cycle after its edge.
- Pending_Cnt is updated every edge by the net change:
  - +1 when an effective reserve targets a bit that is 0 before the edge.
  - -1 when an effective write clears a bit that is 1 and no same-address reserve occurs.
  - Net 0 when both happen on different addresses.
  - Never exceeds 2**RA_WIDTH (or 2**RA_WIDTH-1 with ZERO_REG); never underflows.
- Write to a non-pending register: data updates, count unchanged.
- Rsv_Waw = 1 for one cycle after an effective reserve whose target bit was already 1 before the edge.
  - This includes the same-address write+reserve case when the bit was 1.
  - Pending_Cnt is unchanged in that case.
- No internal state machine beyond the register array, the pending vector and the two output registers.
- Latency:
  - Write to read: 1 cycle (0 with BYPASS).
  - Reserve to Busy: 1 cycle.

Test Plan:
- Reset then read: Rst=1 for 1 cycle, then read r5 and r31 with en=1 -> both Data=0, Busy=0, Pending_Cnt=0.
- Write/read and zero register: write r3=0xDEADBEEF, read r3 next cycle -> 0xDEADBEEF. Write r0=0x1234 with ZERO_REG=1 -> r0 reads 0.
- Bypass: same cycle W_en r7=0xA5A5A5A5 while R1_Addr=7 -> R1_Data=0xA5A5A5A5, R1_Busy=0 (BYPASS=1). With BYPASS=0 it returns the old value 0.
- Scoreboard RAW: reserve r9; next cycle R2_Addr=9 -> R2_Busy=1, Stall=1, Pending_Cnt=1. Write r9=0x55 -> same-cycle R2_Data=0x55, Busy=0; next cycle Pending_Cnt=0.
- WAW and simultaneous events:
  - Reserve r4 twice -> second gives Rsv_Waw pulse, Pending_Cnt stays 1.
  - Same cycle, write r4 and reserve r4 -> r4 stays pending, data updated, Rsv_Waw=1.
  - Same cycle, write r4 and reserve r6 -> Pending_Cnt stays 1 (r6 pending, r4 clear).
- Reset mid-operation: reserve r1, r2, r3 (Pending_Cnt=3), then Rst=1 together with W_en and Rsv_en -> all pending bits 0, Pending_Cnt=0, all registers 0, write ignored.
